paddle_pos_ctrl: RTL and testbench

- Converts player controls into the 8-bit paddle vertical position consumed by the paddle video/segment stage (paddle1_vpos / paddle2_vpos); one instance per player.
- Supports two control modes: digital up/down with per-frame speed ramping, and analog stick with slew limiting.
- Position updates only once per frame, so the value stays constant while the downstream stage compares it against the vertical count.

---
 rtl/paddle_pos_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_paddle_pos_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_pos_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_pos_ctrl
//
// Turns one player's controls into the 8-bit paddle vertical position that
// feeds the paddle video stage (paddle1_vpos / paddle2_vpos). One instance is
// used per player. The position only moves on frame_tick, at vblank start, so
// it stays constant while the video stage compares it against the vertical
// count during the visible frame.
//
// Two control modes:
//   mode = 0 : digital up/down buttons. The step per frame starts at STEP_MIN
//              and grows by one every RAMP_FRAMES held frames, up to STEP_MAX.
//   mode = 1 : analog stick. The target is POS_CENTER + analog/2. The paddle
//              moves toward the target by at most STEP_MAX per frame.
//
// Optional build macro:
//   PADDLE_ATTRACT_EN - adds the active-low _attract input. While it is low,
//                       the controls are ignored and the paddle bounces
//                       between POS_MIN and POS_MAX, moving STEP_MIN per
//                       frame. Undefined by default, which leaves out both
//                       the port and the sweep logic.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high; has priority over frame_tick
//   frame_tick  in   one-cycle pulse at vblank start; the only update strobe
//   mode        in   0 = digital buttons, 1 = analog stick
//   btn_up      in   digital up (decreases vpos)
//   btn_down    in   digital down (increases vpos)
//   analog[7:0] in   signed stick value, -128..127
//   _attract    in   (PADDLE_ATTRACT_EN only) active-low attract sweep
//   vpos[7:0]   out  registered paddle position, always in [POS_MIN, POS_MAX]
//   moving      out  1 when the last frame_tick changed vpos
//   at_limit    out  1 when vpos is at POS_MIN or POS_MAX
//
// Digital FSM states:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no direction held (or analog/attract active); the next
//            | press moves STEP_MIN
//   ST_MOVE  | a direction is held; step ramps while the same direction
//            | stays held
// ---------------------------------------------------------------------------
module paddle_pos_ctrl #(
    parameter logic [7:0] POS_MIN     = 8'd16,
    parameter logic [7:0] POS_MAX     = 8'd224,
    parameter logic [2:0] STEP_MIN    = 3'd1,
    parameter logic [2:0] STEP_MAX    = 3'd6,
    parameter int         RAMP_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] analog,
`ifdef PADDLE_ATTRACT_EN
    input  logic       _attract,
`endif
    output logic [7:0] vpos,
    output logic       moving,
    output logic       at_limit
);

    localparam logic [8:0] CENTER_SUM = {1'b0, POS_MIN} + {1'b0, POS_MAX};
    localparam logic [7:0] POS_CENTER = CENTER_SUM[8:1];

    // All position arithmetic is carried in 10-bit signed so that an
    // overshoot past either limit is visible before clamping.
    localparam logic signed [9:0] MIN_S    = $signed({2'b00, POS_MIN});
    localparam logic signed [9:0] MAX_S    = $signed({2'b00, POS_MAX});
    localparam logic signed [9:0] CENTER_S = $signed({2'b00, POS_CENTER});
    localparam logic signed [9:0] SMAX_S   = $signed({7'b000_0000, STEP_MAX});
    localparam logic signed [9:0] SMIN_S   = $signed({7'b000_0000, STEP_MIN});

    localparam int RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MOVE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t                   state_q,    state_d;
    logic        [2:0]        step_q,     step_d;
    logic        [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic signed [1:0]        last_dir_q, last_dir_d;
    logic                     mode_q,     mode_d;
    logic        [7:0]        vpos_q,     vpos_d;
    logic                     moving_q,   moving_d;
    logic                     at_limit_q, at_limit_d;
`ifdef PADDLE_ATTRACT_EN
    // Sweep direction during attract: 0 = downward (vpos increasing).
    logic                     sweep_up_q, sweep_up_d;
`endif

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic signed [1:0] dir;
    state_t            state_eff;
    logic signed [9:0] cur_s;
    logic signed [9:0] step_s;
    logic signed [7:0] half_s;
    logic signed [9:0] analog_ext;
    logic        [7:0] target;
    logic signed [9:0] target_s;
    logic signed [9:0] diff_s;
    logic signed [9:0] sum_s;

    function automatic logic [7:0] clamp_pos(input logic signed [9:0] v);
        if (v < MIN_S) begin
            return POS_MIN;
        end else if (v > MAX_S) begin
            return POS_MAX;
        end else begin
            return v[7:0];
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        ramp_cnt_d = ramp_cnt_q;
        last_dir_d = last_dir_q;
        mode_d     = mode_q;
        vpos_d     = vpos_q;
        moving_d   = moving_q;
        at_limit_d = at_limit_q;
`ifdef PADDLE_ATTRACT_EN
        sweep_up_d = sweep_up_q;
`endif

        // Both buttons cancel each other out, like neither.
        dir = 2'sd0;
        if (btn_up && !btn_down) begin
            dir = -2'sd1;
        end else if (btn_down && !btn_up) begin
            dir = 2'sd1;
        end

        // A mode change since the previous tick restarts the digital ramp.
        state_eff = (mode != mode_q) ? ST_IDLE : state_q;

        cur_s  = $signed({2'b00, vpos_q});
        step_s = $signed({7'b000_0000, step_q});

        half_s     = $signed(analog) >>> 1;
        analog_ext = {{2{half_s[7]}}, half_s};
        target     = clamp_pos(CENTER_S + analog_ext);
        target_s   = $signed({2'b00, target});
        diff_s     = target_s - cur_s;

        sum_s = cur_s;

        if (frame_tick) begin
            mode_d = mode;
`ifdef PADDLE_ATTRACT_EN
            // Outside attract the sweep always starts downward next time.
            sweep_up_d = 1'b0;
            if (!_attract) begin
                state_d    = ST_IDLE;
                step_d     = STEP_MIN;
                ramp_cnt_d = '0;
                // Bounce: reverse before stepping past a limit.
                if (!sweep_up_q && vpos_q >= POS_MAX) begin
                    sweep_up_d = 1'b1;
                end else if (sweep_up_q && vpos_q <= POS_MIN) begin
                    sweep_up_d = 1'b0;
                end else begin
                    sweep_up_d = sweep_up_q;
                end
                sum_s = sweep_up_d ? (cur_s - SMIN_S) : (cur_s + SMIN_S);
            end else
`endif
            if (mode) begin
                state_d    = ST_IDLE;
                step_d     = STEP_MIN;
                ramp_cnt_d = '0;
                if (diff_s > SMAX_S) begin
                    sum_s = cur_s + SMAX_S;
                end else if (diff_s < -SMAX_S) begin
                    sum_s = cur_s - SMAX_S;
                end else begin
                    sum_s = target_s;
                end
            end else if (dir == 2'sd0) begin
                state_d    = ST_IDLE;
                step_d     = STEP_MIN;
                ramp_cnt_d = '0;
            end else if (state_eff == ST_IDLE || dir != last_dir_q) begin
                // Fresh press or reversal: always the smallest step.
                state_d    = ST_MOVE;
                step_d     = STEP_MIN;
                ramp_cnt_d = '0;
                last_dir_d = dir;
                sum_s      = (dir == 2'sd1) ? (cur_s + SMIN_S) : (cur_s - SMIN_S);
            end else begin
                // Held direction: move by the current step, then ramp.
                state_d = ST_MOVE;
                sum_s   = (dir == 2'sd1) ? (cur_s + step_s) : (cur_s - step_s);
                if (ramp_cnt_q == RAMP_LAST) begin
                    ramp_cnt_d = '0;
                    step_d     = (step_q >= STEP_MAX) ? STEP_MAX : (step_q + 3'd1);
                end else begin
                    ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
                end
            end

            vpos_d     = clamp_pos(sum_s);
            moving_d   = (vpos_d != vpos_q);
            at_limit_d = (vpos_d == POS_MIN) || (vpos_d == POS_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_q     <= STEP_MIN;
            ramp_cnt_q <= '0;
            last_dir_q <= 2'sd0;
            mode_q     <= 1'b0;
            vpos_q     <= POS_CENTER;
            moving_q   <= 1'b0;
            at_limit_q <= 1'b0;
`ifdef PADDLE_ATTRACT_EN
            sweep_up_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            ramp_cnt_q <= ramp_cnt_d;
            last_dir_q <= last_dir_d;
            mode_q     <= mode_d;
            vpos_q     <= vpos_d;
            moving_q   <= moving_d;
            at_limit_q <= at_limit_d;
`ifdef PADDLE_ATTRACT_EN
            sweep_up_q <= sweep_up_d;
`endif
        end
    end

    assign vpos     = vpos_q;
    assign moving   = moving_q;
    assign at_limit = at_limit_q;

endmodule

// File: tb/tb_paddle_pos_ctrl.sv
// Testbench for paddle_pos_ctrl. The reference model tracks the paddle with
// plain integers: the digital step is derived from how many consecutive
// frames the same direction has been held, not from a ramp counter.
module tb_paddle_pos_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       mode;
    logic       btn_up;
    logic       btn_down;
    logic [7:0] analog;
`ifdef PADDLE_ATTRACT_EN
    logic       attract_n;
`endif
    logic [7:0] vpos;
    logic       moving;
    logic       at_limit;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_vpos;
    bit m_moving;
    bit m_limit;
    int m_prev_mode;
    int m_run_len;   // consecutive frames the same direction has been held
    int m_run_dir;
    int m_sweep;     // +1 = downward, -1 = upward

    paddle_pos_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .mode       (mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .analog     (analog),
`ifdef PADDLE_ATTRACT_EN
        ._attract   (attract_n),
`endif
        .vpos       (vpos),
        .moving     (moving),
        .at_limit   (at_limit)
    );

    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic int clampi(input int v);
        if (v < 16) return 16;
        if (v > 224) return 224;
        return v;
    endfunction

    task automatic model_reset();
        m_vpos      = 120;
        m_moving    = 0;
        m_limit     = 0;
        m_prev_mode = 0;
        m_run_len   = 0;
        m_run_dir   = 0;
        m_sweep     = 1;
    endtask

    task automatic model_tick(input bit up, input bit dn, input bit md,
                              input logic [7:0] an, input bit att_n);
        int old_v;
        int nv;
        int d;
        int a;
        int tgt;
        int n;
        int stp;
        old_v = m_vpos;
        nv    = old_v;
        d     = (up && !dn) ? -1 : ((dn && !up) ? 1 : 0);
        if (!att_n) begin
            if (m_sweep > 0 && old_v >= 224) m_sweep = -1;
            else if (m_sweep < 0 && old_v <= 16) m_sweep = 1;
            nv = clampi(old_v + m_sweep);
            m_run_len = 0;
        end else begin
            m_sweep = 1;
            if (md) begin
                a   = int'($signed(an));
                tgt = clampi(120 + (a >>> 1));
                if (tgt - old_v > 6) nv = old_v + 6;
                else if (old_v - tgt > 6) nv = old_v - 6;
                else nv = tgt;
                m_run_len = 0;
            end else if (d == 0) begin
                m_run_len = 0;
            end else begin
                n = (m_run_len > 0 && m_run_dir == d && int'(md) == m_prev_mode) ? m_run_len : 0;
                stp = (n == 0) ? 1 : 1 + (n - 1) / 4;
                if (stp > 6) stp = 6;
                nv = clampi(old_v + d * stp);
                m_run_len = n + 1;
                m_run_dir = d;
            end
        end
        m_prev_mode = int'(md);
        m_moving    = (nv != old_v);
        m_limit     = (nv == 16) || (nv == 224);
        m_vpos      = nv;
    endtask

    // Applies one frame tick; outputs are valid when this returns (negedge).
    task automatic tick(input bit up, input bit dn, input bit md,
                        input logic [7:0] an, input bit att_n);
        @(negedge clk);
        btn_up     = up;
        btn_down   = dn;
        mode       = md;
        analog     = an;
`ifdef PADDLE_ATTRACT_EN
        attract_n  = att_n;
`endif
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_tick(up, dn, md, an, att_n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b0;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        mode       = 1'b0;
        analog     = 8'h00;
`ifdef PADDLE_ATTRACT_EN
        attract_n  = 1'b1;
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (vpos !== 8'd120) begin
            errors++; $display("FAIL reset_vpos: got %0d expected 120", vpos);
        end
        checks++;
        if (moving !== 1'b0) begin
            errors++; $display("FAIL reset_moving: got %0b expected 0", moving);
        end
        checks++;
        if (at_limit !== 1'b0) begin
            errors++; $display("FAIL reset_at_limit: got %0b expected 0", at_limit);
        end
    endtask

    task automatic test_ramp_down();
        int exp_v[6] = '{121, 122, 123, 124, 125, 127};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
            checks++;
            if (vpos !== 8'(exp_v[i])) begin
                errors++; $display("FAIL ramp_vpos tick %0d: got %0d expected %0d", i, vpos, exp_v[i]);
            end
            checks++;
            if (moving !== 1'b1) begin
                errors++; $display("FAIL ramp_moving tick %0d: got %0b expected 1", i, moving);
            end
        end
    endtask

    task automatic test_mid_ramp_reset();
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        reset      = 1'b1;
        frame_tick = 1'b1;
        btn_down   = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        frame_tick = 1'b0;
        model_reset();
        checks++;
        if (vpos !== 8'd120 || moving !== 1'b0 || at_limit !== 1'b0) begin
            errors++;
            $display("FAIL mid_ramp_reset: got vpos=%0d moving=%0b at_limit=%0b expected 120/0/0",
                     vpos, moving, at_limit);
        end
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if (vpos !== 8'd121) begin
            errors++; $display("FAIL post_reset_step: got %0d expected 121", vpos);
        end
    endtask

    task automatic test_clamp_up();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (vpos !== 8'(m_vpos) || moving !== m_moving || at_limit !== m_limit) begin
                errors++;
                $display("FAIL clamp_up tick %0d: got %0d/%0b/%0b expected %0d/%0b/%0b",
                         i, vpos, moving, at_limit, m_vpos, m_moving, m_limit);
            end
        end
        checks++;
        if (vpos !== 8'd16 || at_limit !== 1'b1 || moving !== 1'b0) begin
            errors++;
            $display("FAIL clamp_final: got vpos=%0d at_limit=%0b moving=%0b expected 16/1/0",
                     vpos, at_limit, moving);
        end
    endtask

    task automatic test_reversal();
        logic [7:0] v;
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        v = vpos;
        checks++;
        if (v !== 8'd125) begin
            errors++; $display("FAIL reversal_pre: got %0d expected 125", v);
        end
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (vpos !== v - 8'd1) begin
            errors++; $display("FAIL reversal_step: got %0d expected %0d", vpos, v - 8'd1);
        end
        tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if (vpos !== v - 8'd1 || moving !== 1'b0) begin
            errors++; $display("FAIL both_pressed: got %0d/%0b expected %0d/0", vpos, moving, v - 8'd1);
        end
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if (vpos !== v) begin
            errors++; $display("FAIL after_idle_step: got %0d expected %0d", vpos, v);
        end
    endtask

    task automatic test_analog();
        int e;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            tick(1'b0, 1'b0, 1'b1, 8'h80, 1'b1);
            e = (k <= 10) ? 120 - 6 * k : 56;
            checks++;
            if (vpos !== 8'(e)) begin
                errors++; $display("FAIL analog_slew tick %0d: got %0d expected %0d", k, vpos, e);
            end
        end
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            analog   = 8'($urandom);
            btn_up   = 1'($urandom);
            btn_down = 1'($urandom);
            mode     = 1'($urandom);
        end
        checks++;
        if (vpos !== 8'd56 || moving !== 1'b0) begin
            errors++; $display("FAIL no_tick_hold: got %0d/%0b expected 56/0", vpos, moving);
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        // analog 14 -> target 127, which is where the paddle already is
        tick(1'b0, 1'b0, 1'b1, 8'h0E, 1'b1);
        checks++;
        if (vpos !== 8'd127 || moving !== 1'b0) begin
            errors++; $display("FAIL mode_analog_hold: got %0d/%0b expected 127/0", vpos, moving);
        end
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        checks++;
        if (vpos !== 8'd128) begin
            errors++; $display("FAIL mode_switch_step: got %0d expected 128", vpos);
        end
    endtask

    task automatic test_random();
        bit up, dn, md, att_n;
        logic [7:0] an;
        do_reset();
        up = 0; dn = 0; md = 0; an = 8'h00; att_n = 1;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                up = 1'($urandom);
                dn = 1'($urandom);
                md = ($urandom_range(0, 3) == 0);
                an = 8'($urandom);
            end
`ifdef PADDLE_ATTRACT_EN
            if ($urandom_range(0, 15) == 0) att_n = ~att_n;
`endif
            repeat ($urandom_range(0, 3)) @(negedge clk);
            tick(up, dn, md, an, att_n);
            checks++;
            if (vpos !== 8'(m_vpos) || moving !== m_moving || at_limit !== m_limit) begin
                errors++;
                $display("FAIL random tick %0d: got %0d/%0b/%0b expected %0d/%0b/%0b",
                         i, vpos, moving, at_limit, m_vpos, m_moving, m_limit);
            end
        end
    endtask

`ifdef PADDLE_ATTRACT_EN
    task automatic test_attract();
        int exp_v[4] = '{223, 224, 223, 222};
        do_reset();
        for (int i = 0; i < 60 && m_vpos != 224; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (vpos !== 8'd222) begin
            errors++; $display("FAIL attract_pre: got %0d expected 222", vpos);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            checks++;
            if (vpos !== 8'(exp_v[i])) begin
                errors++; $display("FAIL attract_sweep tick %0d: got %0d expected %0d", i, vpos, exp_v[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            checks++;
            if (vpos !== 8'd222 || moving !== 1'b0) begin
                errors++; $display("FAIL attract_release: got %0d/%0b expected 222/0", vpos, moving);
            end
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        mode       = 1'b0;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        analog     = 8'h00;
`ifdef PADDLE_ATTRACT_EN
        attract_n  = 1'b1;
`endif
        test_reset();
        test_ramp_down();
        test_mid_ramp_reset();
        test_clamp_up();
        test_reversal();
        test_analog();
        test_mode_switch();
`ifdef PADDLE_ATTRACT_EN
        test_attract();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
